// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file types and constants for the writeback arbiter.
// Optional read bypass in the top level is enabled with macro RF_BYPASS_EN.
package regfile_pkg;

  localparam int RF_AW    = 4;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 16;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  // Width of a requester index; at least one bit even for tiny counts.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational grant, registered priority pointer.
// Grants only while hold is low and reset is released.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int GW  = idx_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            hold,
  output logic [NREQ-1:0] grant,
  output logic [GW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [GW-1:0] rr_ptr;
  logic [GW:0]   cand;

  // Scan rr_ptr, rr_ptr+1, ... modulo NREQ and pick the first valid request.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!rst && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, rr_ptr} + (GW+1)'(k);
        if (cand >= (GW+1)'(NREQ)) begin
          cand = cand - (GW+1)'(NREQ);
        end
        if (!grant_any && req[cand[GW-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[GW-1:0];
        end
      end
    end
  end

  // One-hot grant derived from the winning index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign grant[gi] = grant_any && (grant_idx == GW'(gi));
  end

  // Pointer moves just past the winner after every transfer, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == GW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares one register-file write port among NREQ requesters
// with round-robin grant and a single registered output stage.
// Define RF_BYPASS_EN to add two combinational write-to-read bypass ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW,
  localparam int GW  = idx_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              hold,
  output logic              wport_enable,
  output logic [AW-1:0]     wport_addr,
  output logic [DW-1:0]     wport_data,
  output logic [2**AW-1:0]  pending_mask,
`ifdef RF_BYPASS_EN
  input  logic [AW-1:0]     rport1_addr,
  input  logic [AW-1:0]     rport2_addr,
  input  logic [DW-1:0]     rf_rport1_data,
  input  logic [DW-1:0]     rf_rport2_data,
  output logic [DW-1:0]     rport1_data,
  output logic [DW-1:0]     rport2_data,
`endif
  output logic [GW-1:0]     grant_id
);

  logic [NREQ-1:0] grant;
  logic [GW-1:0]   grant_idx;
  logic            grant_any;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .hold      (hold),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Ready is the grant itself: independent of request address and data.
  assign req_ready = grant;

  // Unpack the per-requester address and data lanes.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*AW +: AW];
    assign data_arr[gi] = req_data[gi*DW +: DW];
  end

  // Output stage: load the winner on a transfer, otherwise just drop enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wport_enable <= 1'b0;
      wport_addr   <= '0;
      wport_data   <= '0;
      grant_id     <= '0;
    end else begin
      wport_enable <= grant_any;
      if (grant_any) begin
        wport_addr <= addr_arr[grant_idx];
        wport_data <= data_arr[grant_idx];
        grant_id   <= grant_idx;
      end
    end
  end

  // In-flight write indicator: one-hot of the address held in the output stage.
  for (genvar gi = 0; gi < 2**AW; gi++) begin : g_pending
    assign pending_mask[gi] = wport_enable && (wport_addr == AW'(gi));
  end

`ifdef RF_BYPASS_EN
  // Forward the write being committed this cycle to matching read ports.
  assign rport1_data = (wport_enable && (rport1_addr == wport_addr)) ? wport_data : rf_rport1_data;
  assign rport2_data = (wport_enable && (rport2_addr == wport_addr)) ? wport_data : rf_rport2_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=2, AW=4, DW=32) with a small
// register-file model on the write port.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_addr;
  logic [63:0] req_data;
  logic        hold;
  logic        wport_enable;
  logic [3:0]  wport_addr;
  logic [31:0] wport_data;
  logic [15:0] pending_mask;
  logic [0:0]  grant_id;
`ifdef RF_BYPASS_EN
  logic [3:0]  rport1_addr, rport2_addr;
  logic [31:0] rf_rport1_data, rf_rport2_data, rport1_data, rport2_data;
`endif

  int nvec  = 0;
  int nfail = 0;

  logic [31:0] rf_model [16];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(2), .AW(4), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .hold         (hold),
    .wport_enable (wport_enable),
    .wport_addr   (wport_addr),
    .wport_data   (wport_data),
    .pending_mask (pending_mask),
`ifdef RF_BYPASS_EN
    .rport1_addr    (rport1_addr),
    .rport2_addr    (rport2_addr),
    .rf_rport1_data (rf_rport1_data),
    .rf_rport2_data (rf_rport2_data),
    .rport1_data    (rport1_data),
    .rport2_data    (rport2_data),
`endif
    .grant_id     (grant_id)
  );

  // Register file: commits the output stage on the edge after it is loaded.
  always @(posedge clk) begin
    if (wport_enable && !rst) rf_model[wport_addr] <= wport_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [31:0] d);
    req_valid[i]        = v;
    req_addr[i*4 +: 4]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rf_model[r] = '0;
    rst = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
`ifdef RF_BYPASS_EN
    rport1_addr = 4'h0; rport2_addr = 4'h1;
    rf_rport1_data = 32'h1111_1111; rf_rport2_data = 32'h2222_2222;
`endif

    // Reset then idle
    step(); step();
    #1;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_wen", 64'(wport_enable), 64'h0);
    check("rst_pend", 64'(pending_mask), 64'h0);
    check("rst_waddr", 64'(wport_addr), 64'h0);
    check("rst_gid", 64'(grant_id), 64'h0);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      check("idle_wen", 64'(wport_enable), 64'h0);
      check("idle_ready", 64'(req_ready), 64'h0);
      check("idle_pend", 64'(pending_mask), 64'h0);
    end

    // Single write: req0 -> r2 = FFFFFFFF
    set_req(0, 1'b1, 4'h2, 32'hFFFF_FFFF);
    #1;
    check("single_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    check("single_wen", 64'(wport_enable), 64'h1);
    check("single_waddr", 64'(wport_addr), 64'h2);
    check("single_wdata", 64'(wport_data), 64'hFFFF_FFFF);
    check("single_pend", 64'(pending_mask), 64'h0004);
    check("single_gid", 64'(grant_id), 64'h0);
    step();
    check("single_rf2", 64'(rf_model[2]), 64'hFFFF_FFFF);
    check("single_wen_off", 64'(wport_enable), 64'h0);
    check("single_waddr_hold", 64'(wport_addr), 64'h2);

    // Contention from reset: grants 0,1,0 then hold with rr_ptr=1
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 4'h1, 32'h0000_000A);
    set_req(1, 1'b1, 4'h3, 32'h0000_000B);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("cont_ready", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
      step();
      check("cont_gid", 64'(grant_id), 64'(i % 2));
      check("cont_waddr", 64'(wport_addr), (i % 2 == 0) ? 64'h1 : 64'h3);
      check("cont_wdata", 64'(wport_data), (i % 2 == 0) ? 64'hA : 64'hB);
    end

    // Hold for 3 cycles: in-flight write to r1 still commits
    hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("hold_ready", 64'(req_ready), 64'h0);
      step();
      check("hold_wen", 64'(wport_enable), 64'h0);
    end
    check("hold_rf1", 64'(rf_model[1]), 64'hA);
    hold = 1'b0;
    #1;
    check("resume_ready", 64'(req_ready), 64'h2);
    step();
    check("resume_gid", 64'(grant_id), 64'h1);
    check("resume_waddr", 64'(wport_addr), 64'h3);

    // Same address, consecutive grants: last granted wins
    set_req(0, 1'b1, 4'h7, 32'h0000_0011);
    set_req(1, 1'b1, 4'h7, 32'h0000_0022);
    step();
    check("same_wdata0", 64'(wport_data), 64'h11);
    check("same_pend", 64'(pending_mask), 64'h0080);
    step();
    req_valid = '0;
    check("same_wdata1", 64'(wport_data), 64'h22);
    step();
    check("same_rf7", 64'(rf_model[7]), 64'h22);

    // Reset mid-write to r5: write is discarded
    set_req(0, 1'b1, 4'h5, 32'h0000_0055);
    step();
    check("midrst_wen_pre", 64'(wport_enable), 64'h1);
    rst = 1'b1;
    req_valid = '0;
    step();
    check("midrst_wen", 64'(wport_enable), 64'h0);
    check("midrst_pend", 64'(pending_mask), 64'h0);
    check("midrst_waddr", 64'(wport_addr), 64'h0);
    rst = 1'b0;
    step();
    step();
    check("midrst_rf5", 64'(rf_model[5]), 64'h0);

`ifdef RF_BYPASS_EN
    // Bypass: r0 write visible on rport1 while in the output stage
    #1;
    check("byp_idle1", 64'(rport1_data), 64'h1111_1111);
    set_req(0, 1'b1, 4'h0, 32'hF00A_F00A);
    step();
    req_valid = '0;
    check("byp_rport1", 64'(rport1_data), 64'hF00A_F00A);
    check("byp_rport2", 64'(rport2_data), 64'h2222_2222);
    step();
    check("byp_off1", 64'(rport1_data), 64'h1111_1111);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
